clk_div_multi: RTL and testbench
================================

Name: clk_div_multi

Overview:
- Multi-channel programmable clock/tick generator. Parametrised successor to the single-channel divider.
- Each of NUM_CH independent channels divides clk by a runtime divisor and produces a square-ish outClk with programmable high time, plus a one-cycle end-of-period tick.
- New divisor/high-time values are double-buffered and applied only at a period boundary, so outputs never glitch.
- Feeds LED blinkers, display scan timing and sample strobes in the lab designs.

Parameters:
- NUM_CH, 4, number of independent channels.
- CNT_W, 27, width of period counter and of each divisor/high-time field.
- DEFAULT_DIV, 50000000, active divisor after reset (must fit CNT_W).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- en  input  NUM_CH  per-channel run enable.
- div  input  NUM_CH*CNT_W  period in clk cycles; channel i at [i*CNT_W +: CNT_W].
- high  input  NUM_CH*CNT_W  high time in clk cycles; same packing.
- load  input  NUM_CH  per-channel request to capture div/high.
- outClk  output  NUM_CH  divided clock per channel.
- tick  output  NUM_CH  1-cycle pulse on the last cycle of each period.
- pending  output  NUM_CH  shadow values captured, not yet applied.

Behaviour:
- Per-channel state:
  - run flag (IDLE/RUN)
  - cnt[CNT_W-1:0]
  - act_div, act_high
  - sh_div, sh_high
  - pending
- Reset (sync, overrides everything including load/en):
  - run=0, cnt=0, outClk=0, tick=0, pending=0.
  - act_div=DEFAULT_DIV, act_high=DEFAULT_DIV/2 (integer floor).
- Effective values, computed combinationally from act_*:
  - eff_div = (act_div<2) ? 2 : act_div.
  - eff_high = (act_high==0) ? 1 : (act_high>=eff_div) ? eff_div-1 : act_high.
  - Every running channel therefore toggles; fastest is clk/2.
- IDLE -> RUN: on the edge where en[i]=1 and run=0.
  - run<=1, cnt<=0.
  - First outClk=1 appears on the cycle after en is sampled.
- RUN:
  - cnt increments each clk and wraps from eff_div-1 to 0.
- RUN -> IDLE: on the edge where en[i]=0.
  - run<=0, cnt<=0, outClk<=0, tick<=0 next cycle (immediate stop, no period completion).
  - act_*, sh_* and pending are retained.
- Outputs are registers, aligned with cnt:
  - outClk = run && (cnt < eff_high).
  - tick = run && (cnt == eff_div-1).
  - Period is exactly eff_div cycles; high time exactly eff_high cycles.
- Load handling:
  - load[i] captures div/high slice into sh_* and sets pending.
  - Boundary = cycle with run && cnt==eff_div-1.
  - At the boundary edge: act_* <= sh_*, pending <= 0, cnt <= 0.
  - load while IDLE: sh_* applied to act_* on the same edge; pending stays 0.
  - load on a boundary cycle: inputs go directly to act_* at that edge; pending stays 0.
  - load while pending: sh_* overwritten; latest value wins.
  - load and en-fall on the same edge: capture proceeds; channel goes IDLE with pending=1; applied at next IDLE cycle.
- Channels fully independent. No cross-channel interaction except the optional sync.
- Widths: cnt compares are unsigned CNT_W; no division operators in RTL.

Optional Feature:
- Macro: CLK_DIV_SYNC_EN.
- Defined:
  - Adds input port sync_in (1 bit), placed after reset.
  - sync_in=1 forces every running channel to cnt<=0 on the next edge, applies pending shadows as at a boundary, and suppresses tick that cycle.
  - Used to phase-align all channels.
  - IDLE channels are unaffected.
- Undefined: no port; behaviour exactly as above.

Test Plan:
- Setup: CNT_W=8, DEFAULT_DIV=10, NUM_CH=4.
- 1. Reset, then en[0]=1 with no load -> outClk[0] high 5 / low 5; tick[0] every 10th cycle coincident with cnt=9. Reset mid-run -> all outputs 0 next cycle.
- 2. Ch1 load div=4 high=1 while idle, then en -> pattern 1,0,0,0 repeating; tick on the 4th cycle of each period.
- 3. Ch2 running div=10; load div=6 high=3 at cnt=3 -> pending=1 until the boundary; first new period exactly 6 cycles; no runt pulse.
- 4. Clamps: load div=0 high=0 -> clk/2 (1,0); load div=5 high=9 -> high 4 / low 1.
- 5. en[3] dropped at cnt=2 -> outClk/tick 0 next cycle. Re-enable -> restarts at cnt=0 with retained div.
- 6. (CLK_DIV_SYNC_EN) Channels at div 10 and 4, skewed; pulse sync_in -> both outClk rise on the same cycle after; no tick that cycle.

Source files
------------

// File: rtl/clk_div_multi.sv
// clk_div_multi: multi-channel programmable clock/tick generator.
//
// Each channel divides clk by a runtime period (act_div) and drives a
// registered outClk that is high for act_high cycles of every period, plus
// a one-cycle tick on the last cycle of the period. New div/high values are
// captured into a shadow register on load and only moved into the active
// registers at a period boundary (or immediately while the channel is idle),
// so a running output never produces a runt pulse.
//
// Optional feature macro: CLK_DIV_SYNC_EN
//   When defined, adds input sync_in. A high sync_in restarts every running
//   channel at cnt=0 on the next edge, applies any pending shadow values as
//   at a boundary, and (because cnt restarts at 0) no tick is produced on
//   that cycle. Idle channels ignore sync_in.
//
// Counters and compares are unsigned CNT_W wide; no division is used.

module clk_div_multi #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 27,
  parameter int DEFAULT_DIV = 50000000
) (
  input  logic                    clk,
  input  logic                    reset,
`ifdef CLK_DIV_SYNC_EN
  input  logic                    sync_in,
`endif
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH*CNT_W-1:0] div,
  input  logic [NUM_CH*CNT_W-1:0] high,
  input  logic [NUM_CH-1:0]       load,
  output logic [NUM_CH-1:0]       outClk,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       pending
);

  // Reset values of the active registers; high time is floor(DEFAULT_DIV/2).
  localparam logic [CNT_W-1:0] DEF_DIV  = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] DEF_HIGH = DEF_DIV >> 1;
  localparam logic [CNT_W-1:0] ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);

  // Effective period: anything below 2 is clamped to 2 (fastest is clk/2).
  function automatic logic [CNT_W-1:0] f_eff_div(input logic [CNT_W-1:0] d);
    logic [CNT_W-1:0] r;
    if (d < TWO) begin
      r = TWO;
    end else begin
      r = d;
    end
    return r;
  endfunction

  // Effective high time: at least 1, at most one less than the period, so
  // every running channel has both a high and a low phase.
  function automatic logic [CNT_W-1:0] f_eff_high(input logic [CNT_W-1:0] h,
                                                  input logic [CNT_W-1:0] ed);
    logic [CNT_W-1:0] r;
    if (h == ZERO) begin
      r = ONE;
    end else if (h >= ed) begin
      r = ed - ONE;
    end else begin
      r = h;
    end
    return r;
  endfunction

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch

    logic             run_q,      run_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [CNT_W-1:0] act_div_q,  act_div_d;
    logic [CNT_W-1:0] act_high_q, act_high_d;
    logic [CNT_W-1:0] sh_div_q,   sh_div_d;
    logic [CNT_W-1:0] sh_high_q,  sh_high_d;
    logic             pend_q,     pend_d;
    logic             out_q,      out_d;
    logic             tick_q,     tick_d;

    logic [CNT_W-1:0] div_in_s;
    logic [CNT_W-1:0] high_in_s;
    logic [CNT_W-1:0] last_s;
    logic [CNT_W-1:0] nxt_last_s;
    logic [CNT_W-1:0] nxt_high_s;
    logic             sync_s;
    logic             bnd_s;

    assign div_in_s  = div[i*CNT_W +: CNT_W];
    assign high_in_s = high[i*CNT_W +: CNT_W];

`ifdef CLK_DIV_SYNC_EN
    assign sync_s = sync_in & run_q;
`else
    assign sync_s = 1'b0;
`endif

    // Last count of the current period, from the active values.
    assign last_s = f_eff_div(act_div_q) - ONE;

    // Period boundary: the update point for active values (sync forces one).
    assign bnd_s = run_q & ((cnt_q == last_s) | sync_s);

    // Next-state logic: shadow capture, active update, run/count sequencing.
    always_comb begin
      sh_div_d   = sh_div_q;
      sh_high_d  = sh_high_q;
      act_div_d  = act_div_q;
      act_high_d = act_high_q;
      pend_d     = pend_q;
      run_d      = run_q;
      cnt_d      = cnt_q;

      // A load always refreshes the shadow so the latest request wins.
      if (load[i]) begin
        sh_div_d  = div_in_s;
        sh_high_d = high_in_s;
      end else begin
        sh_div_d  = sh_div_q;
        sh_high_d = sh_high_q;
      end

      // Idle or boundary: a load goes straight to the active registers;
      // otherwise an outstanding shadow is applied. Mid-period: defer.
      if (!run_q || bnd_s) begin
        if (load[i]) begin
          act_div_d  = div_in_s;
          act_high_d = high_in_s;
          pend_d     = 1'b0;
        end else if (pend_q) begin
          act_div_d  = sh_div_q;
          act_high_d = sh_high_q;
          pend_d     = 1'b0;
        end else begin
          act_div_d  = act_div_q;
          act_high_d = act_high_q;
          pend_d     = 1'b0;
        end
      end else if (load[i]) begin
        pend_d = 1'b1;
      end else begin
        pend_d = pend_q;
      end

      // Enable low stops at once; rising enable restarts the period.
      if (!en[i]) begin
        run_d = 1'b0;
        cnt_d = ZERO;
      end else if (!run_q) begin
        run_d = 1'b1;
        cnt_d = ZERO;
      end else if (bnd_s || (cnt_q >= last_s)) begin
        run_d = 1'b1;
        cnt_d = ZERO;
      end else begin
        run_d = 1'b1;
        cnt_d = cnt_q + ONE;
      end
    end

    // Effective values for the next cycle, so outputs stay aligned with cnt.
    assign nxt_last_s = f_eff_div(act_div_d) - ONE;
    assign nxt_high_s = f_eff_high(act_high_d, f_eff_div(act_div_d));

    // Registered output decode from the next-state counter and active values.
    always_comb begin
      out_d  = run_d & (cnt_d < nxt_high_s);
      tick_d = run_d & (cnt_d == nxt_last_s);
    end

    // Channel state registers with synchronous reset.
    always_ff @(posedge clk) begin
      if (reset) begin
        run_q      <= 1'b0;
        cnt_q      <= ZERO;
        act_div_q  <= DEF_DIV;
        act_high_q <= DEF_HIGH;
        sh_div_q   <= DEF_DIV;
        sh_high_q  <= DEF_HIGH;
        pend_q     <= 1'b0;
        out_q      <= 1'b0;
        tick_q     <= 1'b0;
      end else begin
        run_q      <= run_d;
        cnt_q      <= cnt_d;
        act_div_q  <= act_div_d;
        act_high_q <= act_high_d;
        sh_div_q   <= sh_div_d;
        sh_high_q  <= sh_high_d;
        pend_q     <= pend_d;
        out_q      <= out_d;
        tick_q     <= tick_d;
      end
    end

    assign outClk[i]  = out_q;
    assign tick[i]    = tick_q;
    assign pending[i] = pend_q;

  end : g_ch

endmodule : clk_div_multi

// File: tb/tb_clk_div_multi.sv
// Testbench for clk_div_multi (NUM_CH=4, CNT_W=8, DEFAULT_DIV=10).
// A period/phase model of every channel is stepped on each clock edge and
// all outputs are compared against it after every edge; directed scenarios
// add literal expected waveforms, then randomized stimulus follows.

module tb_clk_div_multi;

  localparam int NCH = 4;
  localparam int CW  = 8;

  logic            clk;
  logic            reset;
`ifdef CLK_DIV_SYNC_EN
  logic            sync_in;
`endif
  logic [NCH-1:0]    en;
  logic [NCH*CW-1:0] div;
  logic [NCH*CW-1:0] high;
  logic [NCH-1:0]    load;
  logic [NCH-1:0]    outClk;
  logic [NCH-1:0]    tick;
  logic [NCH-1:0]    pending;

  int n_chk  = 0;
  int n_pass = 0;

  // Model state per channel: running, position within period, active and
  // shadow period/high values, pending flag.
  int m_run  [NCH];
  int m_pos  [NCH];
  int m_div  [NCH];
  int m_high [NCH];
  int m_sdiv [NCH];
  int m_shigh[NCH];
  int m_pend [NCH];

  clk_div_multi #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_DIV(10)) dut (
    .clk    (clk),
    .reset  (reset),
`ifdef CLK_DIV_SYNC_EN
    .sync_in(sync_in),
`endif
    .en     (en),
    .div    (div),
    .high   (high),
    .load   (load),
    .outClk (outClk),
    .tick   (tick),
    .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int effd(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  function automatic int effh(input int h, input int d);
    int ed;
    ed = effd(d);
    if (h == 0) return 1;
    if (h >= ed) return ed - 1;
    return h;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_step();
    int d_in, h_in, ed;
    bit at_end;
    for (int i = 0; i < NCH; i++) begin
      d_in = int'(div[i*CW +: CW]);
      h_in = int'(high[i*CW +: CW]);
      if (reset) begin
        m_run[i] = 0; m_pos[i] = 0; m_div[i] = 10; m_high[i] = 5; m_pend[i] = 0;
      end else begin
        ed = effd(m_div[i]);
        at_end = (m_run[i] != 0) && (m_pos[i] == ed - 1);
        if (load[i]) begin
          m_sdiv[i] = d_in; m_shigh[i] = h_in;
        end
        if (m_run[i] == 0 || at_end) begin
          if (load[i]) begin
            m_div[i] = d_in; m_high[i] = h_in; m_pend[i] = 0;
          end else if (m_pend[i] != 0) begin
            m_div[i] = m_sdiv[i]; m_high[i] = m_shigh[i]; m_pend[i] = 0;
          end
        end else if (load[i]) begin
          m_pend[i] = 1;
        end
        if (!en[i]) begin
          m_run[i] = 0; m_pos[i] = 0;
        end else if (m_run[i] == 0) begin
          m_run[i] = 1; m_pos[i] = 0;
        end else begin
          m_pos[i] = at_end ? 0 : m_pos[i] + 1;
        end
      end
    end
  endtask

  // One clock: step the model at the edge, then compare all outputs.
  task automatic cyc();
    logic [NCH-1:0] e_out, e_tick, e_pend;
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < NCH; i++) begin
      e_out[i]  = (m_run[i] != 0) && (m_pos[i] < effh(m_high[i], m_div[i]));
      e_tick[i] = (m_run[i] != 0) && (m_pos[i] == effd(m_div[i]) - 1);
      e_pend[i] = (m_pend[i] != 0);
    end
    chk("model_outClk",  32'(outClk),  32'(e_out));
    chk("model_tick",    32'(tick),    32'(e_tick));
    chk("model_pending", 32'(pending), 32'(e_pend));
  endtask

  task automatic rec(input int ch, input int n, output logic [31:0] o, output logic [31:0] t);
    o = 32'h0;
    t = 32'h0;
    for (int k = 0; k < n; k++) begin
      cyc();
      o[k] = outClk[ch];
      t[k] = tick[ch];
    end
  endtask

  logic [31:0] so, st;

  initial begin
    for (int i = 0; i < NCH; i++) begin
      m_run[i] = 0; m_pos[i] = 0; m_div[i] = 10; m_high[i] = 5;
      m_sdiv[i] = 10; m_shigh[i] = 5; m_pend[i] = 0;
    end
    reset = 1'b1;
`ifdef CLK_DIV_SYNC_EN
    sync_in = 1'b0;
`endif
    en = 4'b0000; load = 4'b0000; div = 32'h0; high = 32'h0;
    cyc(); cyc(); cyc();
    chk("reset_outClk",  32'(outClk),  32'h0);
    chk("reset_tick",    32'(tick),    32'h0);
    chk("reset_pending", 32'(pending), 32'h0);
    reset = 1'b0;

    // Default divisor 10: high 5 / low 5, tick at the 10th cycle.
    en = 4'b0001;
    rec(0, 20, so, st);
    chk("default_out",  so, 32'h0007C1F);
    chk("default_tick", st, 32'h0080200);
    reset = 1'b1;
    cyc();
    chk("midrun_reset_out",  32'(outClk), 32'h0);
    chk("midrun_reset_tick", 32'(tick),   32'h0);
    reset = 1'b0; en = 4'b0000;
    cyc();

    // Load while idle, then run: div 4 high 1.
    load = 4'b0010; div[15:8] = 8'd4; high[15:8] = 8'd1;
    cyc();
    load = 4'b0000;
    en = 4'b0010;
    rec(1, 8, so, st);
    chk("div4_out",  so, 32'h11);
    chk("div4_tick", st, 32'h88);

    // Mid-period load is deferred to the boundary.
    en = 4'b0110;
    cyc(); cyc(); cyc(); cyc();
    load = 4'b0100; div[23:16] = 8'd6; high[23:16] = 8'd3;
    cyc();
    chk("deferred_pending", 32'(pending[2]), 32'h1);
    load = 4'b0000;
    cyc(); cyc(); cyc(); cyc(); cyc();
    chk("old_period_tick",    32'(tick[2]),    32'h1);
    chk("old_period_pending", 32'(pending[2]), 32'h1);
    rec(2, 12, so, st);
    chk("new_period_out",  so, 32'h1C7);
    chk("new_period_tick", st, 32'h820);
    chk("applied_pending", 32'(pending[2]), 32'h0);

    // Clamps: div 0 high 0 -> clk/2; div 5 high 9 -> high 4 low 1.
    en = 4'b0000;
    cyc();
    load = 4'b0001; div[7:0] = 8'd0; high[7:0] = 8'd0;
    cyc();
    load = 4'b0000; en = 4'b0001;
    rec(0, 6, so, st);
    chk("clamp_min_out",  so, 32'h15);
    chk("clamp_min_tick", st, 32'h2A);
    en = 4'b0000;
    cyc();
    load = 4'b0001; div[7:0] = 8'd5; high[7:0] = 8'd9;
    cyc();
    load = 4'b0000; en = 4'b0001;
    rec(0, 10, so, st);
    chk("clamp_high_out",  so, 32'h1EF);
    chk("clamp_high_tick", st, 32'h210);

    // Stop at cnt=2, then restart with the retained divisor.
    en = 4'b0000;
    cyc();
    load = 4'b1000; div[31:24] = 8'd7; high[31:24] = 8'd2;
    cyc();
    load = 4'b0000; en = 4'b1000;
    cyc(); cyc(); cyc();
    en = 4'b0000;
    cyc();
    chk("stop_out",  32'(outClk[3]), 32'h0);
    chk("stop_tick", 32'(tick[3]),   32'h0);
    cyc();
    en = 4'b1000;
    rec(3, 7, so, st);
    chk("restart_out",  so, 32'h03);
    chk("restart_tick", st, 32'h40);

    // Randomized stimulus against the model.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 29) == 0) en[i] = ~en[i];
        load[i] = ($urandom_range(0, 11) == 0);
        div[i*CW +: CW]  = 8'($urandom_range(0, 12));
        high[i*CW +: CW] = 8'($urandom_range(0, 14));
      end
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_clk_div_multi
